// File: rtl/jam_pkg.sv
// Shared types and default sizing for the job-assignment cost table.
package jam_pkg;
  typedef enum logic {LOAD = 1'b0, SERVE = 1'b1} state_t;

  localparam int N_WORKERS_DEF = 8;
  localparam int COST_W_DEF    = 7;
  localparam int IDX_W         = $clog2(N_WORKERS_DEF);
  localparam int CNT_W         = $clog2(N_WORKERS_DEF * N_WORKERS_DEF) + 1;
  localparam int SUM_W         = COST_W_DEF + 2 * IDX_W;
endpackage

// File: rtl/jam_cost_ram.sv
// Cost storage: one synchronous write port, one asynchronous read port, no reset.
module jam_cost_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 7
) (
  input  logic          CLK,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/jam_cost_table.sv
// Loads an N x N cost matrix row-major over valid/ready, then serves Cost[W][J] combinationally.
// Optional running sum of loaded entries is built when JAM_COST_SUM_EN is defined.
module jam_cost_table
  import jam_pkg::*;
#(
  parameter int N_WORKERS = N_WORKERS_DEF,
  parameter int COST_W    = COST_W_DEF,
  localparam int IW       = $clog2(N_WORKERS),
  localparam int CW       = $clog2(N_WORKERS * N_WORKERS) + 1,
  localparam int SW       = COST_W + 2 * IW,
  localparam int DEPTH    = N_WORKERS * N_WORKERS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COST_W-1:0] in_data,
  input  logic              clear,
  output logic              tbl_ready,
  input  logic [IW-1:0]     W,
  input  logic [IW-1:0]     J,
  output logic [COST_W-1:0] Cost,
  output logic [SW-1:0]     cost_sum
);
  state_t            r_state;
  logic [CW-1:0]     r_addr;
  logic              w_accept;
  logic              w_last;
  logic [COST_W-1:0] w_rd;

  // clear wins over a same-cycle beat: no handshake, no write
  assign in_ready  = (r_state == LOAD) & ~clear;
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_addr == CW'(DEPTH - 1));
  assign tbl_ready = (r_state == SERVE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= LOAD;
      r_addr  <= '0;
    end else if (clear) begin
      r_state <= LOAD;
      r_addr  <= '0;
    end else if (w_accept) begin
      r_addr <= r_addr + 1'b1;
      if (w_last) r_state <= SERVE;
    end
  end

  jam_cost_ram #(.DEPTH(DEPTH), .AW(2 * IW), .DW(COST_W)) u_ram (
    .CLK    (CLK),
    .i_we   (w_accept),
    .i_waddr(r_addr[2*IW-1:0]),
    .i_wdata(in_data),
    .i_raddr({W, J}),
    .o_rdata(w_rd)
  );

  assign Cost = tbl_ready ? w_rd : '0;

`ifdef JAM_COST_SUM_EN
  logic [SW-1:0] r_sum;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           r_sum <= '0;
    else if (clear)    r_sum <= '0;
    else if (w_accept) r_sum <= r_sum + SW'(in_data);
  end

  assign cost_sum = r_sum;
`else
  assign cost_sum = '0;
`endif
endmodule

// File: tb/tb_jam_cost_table.sv
// Scoreboard bench for jam_cost_table: stimulus pushes expectations, a negedge monitor checks them.
module tb_jam_cost_table;
`ifdef JAM_COST_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic        CLK, RST, in_valid, clear;
  logic [6:0]  in_data;
  logic [2:0]  W, J;
  logic        in_ready, tbl_ready;
  logic [6:0]  Cost;
  logic [12:0] cost_sum;

  jam_cost_table dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .clear(clear), .tbl_ready(tbl_ready), .W(W), .J(J), .Cost(Cost), .cost_sum(cost_sum)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // 0: Cost, 1: tbl_ready, 2: in_ready, 3: cost_sum
  typedef struct {
    int    sel;
    int    exp;
    string name;
  } chk_t;

  chk_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model: the matrix as the loader intended it
  int m_tbl[64];
  int m_ptr  = 0;
  bit m_load = 1'b1;
  int m_sum  = 0;

  always @(negedge CLK) begin
    while (q.size() > 0) begin
      chk_t c;
      int   act;
      c = q.pop_front();
      case (c.sel)
        0:       act = int'(Cost);
        1:       act = int'(tbl_ready);
        2:       act = int'(in_ready);
        default: act = int'(cost_sum);
      endcase
      n_checks++;
      if (act != c.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
      end
    end
  end

  task automatic push(input int sel, input int exp, input string nm);
    chk_t c;
    c.sel = sel; c.exp = exp; c.name = nm;
    q.push_back(c);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_load = 1'b1; m_sum = 0;
  endtask

  task automatic chk_sum(input string nm);
    push(3, SUM_EN ? m_sum : 0, nm);
  endtask

  task automatic beat(input bit v, input int d, input bit clr);
    in_valid = v; in_data = 7'(d); clear = clr;
    push(2, (m_load && !clr) ? 1 : 0, "in_ready");
    push(1, m_load ? 0 : 1, "tbl_ready");
    @(posedge CLK);
    if (clr) model_reset();
    else if (v && m_load) begin
      m_tbl[m_ptr] = d;
      m_sum += d;
      m_ptr++;
      if (m_ptr == 64) m_load = 1'b0;
    end
    #1;
    in_valid = 1'b0; clear = 1'b0;
  endtask

  // kind: 0 k%128, 1 0x11, 2 random, 3 all 127; gaps: 0 none, 1 alternate, 2 random
  task automatic load_full(input int kind, input int gaps);
    int g = 0;
    while (m_load && g < 1000) begin
      bit v;
      int d;
      case (gaps)
        0:       v = 1'b1;
        1:       v = (g % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      case (kind)
        0:       d = m_ptr % 128;
        1:       d = 'h11;
        2:       d = int'($urandom_range(0, 127));
        default: d = 127;
      endcase
      beat(v, d, 1'b0);
      g++;
    end
    if (m_load) push(1, 1, "load_timeout");
    beat(1'b0, 0, 1'b0);
  endtask

  task automatic rd(input int w, input int j);
    W = 3'(w); J = 3'(j);
    push(0, m_load ? 0 : m_tbl[w*8 + j], $sformatf("cost[%0d][%0d]", w, j));
    @(posedge CLK); #1;
  endtask

  task automatic rd_rand(input int n);
    for (int i = 0; i < n; i++) rd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; in_valid = 1'b0; clear = 1'b0; in_data = '0; W = 3'd3; J = 3'd5;
    push(2, 1, "rst_in_ready"); push(1, 0, "rst_tbl_ready");
    push(0, 0, "rst_cost"); push(3, 0, "rst_cost_sum");
    @(negedge CLK); @(posedge CLK); #1;
    RST = 1'b0;

    // 1: back-to-back k%128
    load_full(0, 0);
    rd(3, 5); push(0, 29, "t1_cost_3_5_const");
    @(posedge CLK); #1;
    rd(7, 7); chk_sum("t1_sum");
    rd_rand(6);

    // 2: alternating stall, same contents
    beat(1'b0, 0, 1'b1);
    load_full(0, 1);
    rd(3, 5); rd(7, 7); rd(0, 0); rd_rand(4); chk_sum("t2_sum");

    // 3: random matrix, clear, reload all 0x11
    beat(1'b0, 0, 1'b1);
    load_full(2, 2);
    rd_rand(4);
    beat(1'b0, 0, 1'b1);
    for (int i = 0; i < 5; i++) beat(1'b1, 'h11, 1'b0);
    rd(2, 2);
    load_full(1, 2);
    for (int k = 0; k < 64; k++) rd(k / 8, k % 8);
    chk_sum("t3_sum");

    // 4: clear collides with beat 10
    beat(1'b0, 0, 1'b1);
    for (int i = 0; i < 10; i++) beat(1'b1, int'($urandom_range(0, 127)), 1'b0);
    beat(1'b1, 'h55, 1'b1);
    load_full(2, 2);
    rd(0, 0); rd(0, 1); rd(1, 2); rd_rand(4); chk_sum("t4_sum");

    // 5: async reset mid-load
    beat(1'b0, 0, 1'b1);
    for (int i = 0; i < 30; i++) beat(1'b1, int'($urandom_range(0, 127)), 1'b0);
    #1 RST = 1'b1;
    model_reset();
    push(2, 1, "t5_in_ready"); push(1, 0, "t5_tbl_ready");
    push(0, 0, "t5_cost"); push(3, 0, "t5_cost_sum");
    @(negedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    load_full(2, 2);
    rd_rand(6); chk_sum("t5_sum");

    // 6: worst-case sum
    beat(1'b0, 0, 1'b1);
    load_full(3, 0);
    push(3, SUM_EN ? 8128 : 0, "t6_cost_sum_max");
    rd(5, 6);
    @(posedge CLK); #1;
    beat(1'b1, 3, 1'b0);
    rd(7, 0); chk_sum("t6_sum_after_serve_valid");

    @(negedge CLK); #1;
    if (q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
